// File: rtl/fpcvt_sched_if.sv
// Handshake bundle between the sample producers/consumer and the shared FPCVT scheduler.
interface fpcvt_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [12*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  logic               out_S;
  logic [2:0]         out_E;
  logic [3:0]         out_F;
  logic [15:0]        conv_count;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_id, out_S, out_E, out_F, conv_count
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_id, out_S, out_E, out_F, conv_count
  );
endinterface

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one FPCVT converter (12-bit two's complement to
// sign / 3-bit exponent / 4-bit significand) among NREQ requesters.
module fpcvt_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  fpcvt_sched_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [11:0]    data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic           out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_s_q, out_s_d;
  logic [2:0]     out_e_q, out_e_d;
  logic [3:0]     out_f_q, out_f_d;
  logic [15:0]    count_q, count_d;

  logic           grantValid;
  logic [IDW-1:0] grantIdx;
  logic [11:0]    grantData;
  logic [NREQ-1:0] grantOneHot;
  logic [IDW:0]   cand;
  logic [IDW-1:0] candIdx;

  // Search starts at ptr and wraps modulo NREQ; the first valid requester wins.
  always_comb begin
    grantValid  = 1'b0;
    grantIdx    = '0;
    grantData   = '0;
    grantOneHot = '0;
    cand        = '0;
    candIdx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      candIdx = cand[IDW-1:0];
      if (!grantValid && bus.req_valid[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
        grantData  = bus.req_data[12*candIdx +: 12];
      end
    end
    if (grantValid) begin
      grantOneHot[grantIdx] = 1'b1;
    end
  end

  assign bus.req_ready = (state_q == IDLE && !rst) ? grantOneHot : '0;

  logic        cvtNeg;
  logic [11:0] cvtMag;
  logic [3:0]  cvtLead;
  logic [3:0]  cvtExp;
  logic        cvtRound;
  logic [4:0]  cvtFrac;
  logic        cvtS;
  logic [2:0]  cvtE;
  logic [3:0]  cvtF;

  // Normalise the magnitude so its leading one lands in F[3], round half-up on
  // the next lower bit, renormalise on carry-out and clamp anything past E=7.
  always_comb begin
    cvtNeg   = data_q[11];
    cvtMag   = cvtNeg ? (~data_q + 12'd1) : data_q;
    cvtLead  = 4'd0;
    for (int b = 0; b < 12; b++) begin
      if (cvtMag[b]) begin
        cvtLead = 4'(b);
      end
    end
    cvtExp   = 4'd0;
    cvtRound = 1'b0;
    cvtFrac  = {1'b0, cvtMag[3:0]};
    if (cvtLead > 4'd3) begin
      cvtExp   = cvtLead - 4'd3;
      cvtRound = |(cvtMag & (12'd1 << (cvtExp - 4'd1)));
      cvtFrac  = 5'((cvtMag >> cvtExp) & 12'h00F) + {4'd0, cvtRound};
    end
    if (cvtFrac[4]) begin
      cvtExp  = cvtExp + 4'd1;
      cvtFrac = 5'd8;
    end
    cvtS = cvtNeg;
    if (cvtExp > 4'd7) begin
      cvtE = 3'd7;
      cvtF = 4'd15;
    end else begin
      cvtE = cvtExp[2:0];
      cvtF = cvtFrac[3:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_s_d     = out_s_q;
    out_e_d     = out_e_q;
    out_f_d     = out_f_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          data_d  = grantData;
          id_d    = grantIdx;
          ptr_d   = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + IDW'(1);
          state_d = CONV;
        end
      end
      CONV: begin
        out_s_d     = cvtS;
        out_e_d     = cvtE;
        out_f_d     = cvtF;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      data_q      <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_s_q     <= out_s_d;
      out_e_q     <= out_e_d;
      out_f_q     <= out_f_d;
      count_q     <= count_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_S      = out_s_q;
  assign bus.out_E      = out_e_q;
  assign bus.out_F      = out_f_q;
  assign bus.conv_count = count_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Self-checking bench for fpcvt_sched: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and conversion.
module tb_fpcvt_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  int   mPtr;
  int   mCount;

  fpcvt_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fpcvt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: smallest exponent whose range holds the magnitude,
  // divide with half-up rounding, renormalise and saturate.
  function automatic logic [7:0] refConvert(input logic [11:0] x);
    int v, mag, e, f;
    logic s;
    v = int'(x);
    if (v >= 2048) v = v - 4096;
    s = (v < 0);
    mag = s ? -v : v;
    e = 0;
    while (e < 8 && mag >= (16 << e)) e++;
    if (e == 0) f = mag;
    else f = (mag + (1 << (e - 1))) >> e;
    if (f == 16) begin
      f = 8;
      e++;
    end
    if (e > 7) begin
      e = 7;
      f = 15;
    end
    return {s, 3'(e), 4'(f)};
  endfunction

  function automatic int refGrant(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int s, input logic [11:0] v);
    bus.req_data[s*12 +: 12] = v;
  endtask

  task automatic scrambleSlots();
    for (int s = 0; s < NREQ; s++) applyStimulus(s, 12'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    scrambleSlots();
    tick();
    nCompared++;
    if (bus.req_ready !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    tick();
    nCompared++;
    if ({bus.out_valid, bus.conv_count} !== 17'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: got valid=%b count=%0d expected 0/0", bus.out_valid, bus.conv_count);
    end
    rst = 1'b0;
    mPtr = 0;
    mCount = 0;
    #1;
    nCompared++;
    if (bus.req_ready !== 4'b0001) begin
      nMismatched++;
      $display("[TB] FAIL reset_first_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    mCount++;
    mPtr = 1;
    nCompared++;
    if ({bus.out_valid, bus.conv_count} !== {1'b0, 16'(mCount)}) begin
      nMismatched++;
      $display("[TB] FAIL reset_first_done: got valid=%b count=%0d expected 0/%0d", bus.out_valid, bus.conv_count, mCount);
    end
  endtask

  task automatic test_single();
    int r;
    logic [11:0] d;
    bus.out_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      r = (it == 0) ? 1 : int'($urandom_range(0, 3));
      d = (it == 0) ? 12'd422 : 12'($urandom);
      applyStimulus(r, d);
      bus.req_valid = 4'(1 << r);
      #1;
      nCompared++;
      if (bus.req_ready !== 4'(1 << r)) begin
        nMismatched++;
        $display("[TB] FAIL single_grant: got %b expected %b", bus.req_ready, 4'(1 << r));
      end
      tick();
      bus.req_valid = 4'b0000;
      scrambleSlots();
      #1;
      nCompared++;
      if ({bus.out_valid, bus.req_ready} !== 5'b0) begin
        nMismatched++;
        $display("[TB] FAIL single_conv: got valid=%b ready=%b expected 0/0000", bus.out_valid, bus.req_ready);
      end
      tick();
      nCompared++;
      if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {1'b1, 2'(r), refConvert(d)}) begin
        nMismatched++;
        $display("[TB] FAIL single_result: got v=%b id=%0d S=%b E=%0d F=%0d expected id=%0d SEF=%h (data %h)",
                 bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F, r, refConvert(d), d);
      end
      if (it == 0) begin
        nCompared++;
        if ({bus.out_S, bus.out_E, bus.out_F} !== {1'b0, 3'd5, 4'd13}) begin
          nMismatched++;
          $display("[TB] FAIL single_422: got S=%b E=%0d F=%0d expected S0 E5 F13", bus.out_S, bus.out_E, bus.out_F);
        end
      end
      tick();
      mCount++;
      mPtr = (r + 1) % NREQ;
      nCompared++;
      if ({bus.out_valid, bus.conv_count, bus.out_S, bus.out_E, bus.out_F} !== {1'b0, 16'(mCount), refConvert(d)}) begin
        nMismatched++;
        $display("[TB] FAIL single_accept: got v=%b count=%0d SEF=%h expected 0/%0d/%h",
                 bus.out_valid, bus.conv_count, {bus.out_S, bus.out_E, bus.out_F}, mCount, refConvert(d));
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    logic [11:0] d;
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    mPtr = 0;
    mCount = 0;
    bus.out_ready = 1'b1;
    scrambleSlots();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      g = refGrant(4'hF, mPtr);
      d = bus.req_data[g*12 +: 12];
      #1;
      nCompared++;
      if (bus.req_ready !== 4'(1 << g)) begin
        nMismatched++;
        $display("[TB] FAIL fair_grant%0d: got %b expected %b", k, bus.req_ready, 4'(1 << g));
      end
      tick();
      applyStimulus(g, 12'($urandom));
      tick();
      nCompared++;
      if ({bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {2'(g), refConvert(d)}) begin
        nMismatched++;
        $display("[TB] FAIL fair_result%0d: got id=%0d SEF=%h expected id=%0d SEF=%h",
                 k, bus.out_id, {bus.out_S, bus.out_E, bus.out_F}, g, refConvert(d));
      end
      tick();
      mCount++;
      mPtr = (g + 1) % NREQ;
    end
    nCompared++;
    if (bus.conv_count !== 16'd6) begin
      nMismatched++;
      $display("[TB] FAIL fair_count: got %0d expected 6", bus.conv_count);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [11:0] d, d2;
    logic [7:0]  held;
    d  = 12'($urandom);
    d2 = 12'($urandom);
    bus.out_ready = 1'b0;
    applyStimulus(3, d);
    bus.req_valid = 4'b1000;
    #1;
    nCompared++;
    if (bus.req_ready !== 4'b1000) begin
      nMismatched++;
      $display("[TB] FAIL bp_grant: got %b expected 1000", bus.req_ready);
    end
    tick();
    applyStimulus(3, d2);
    tick();
    held = refConvert(d);
    for (int w = 0; w < 6; w++) begin
      nCompared++;
      if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F, bus.req_ready, bus.conv_count}
          !== {1'b1, 2'd3, held, 4'b0000, 16'(mCount)}) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d SEF=%h rdy=%b cnt=%0d expected 1/3/%h/0000/%0d",
                 w, bus.out_valid, bus.out_id, {bus.out_S, bus.out_E, bus.out_F}, bus.req_ready,
                 bus.conv_count, held, mCount);
      end
      if (w < 5) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    mCount++;
    mPtr = 0;
    nCompared++;
    if ({bus.out_valid, bus.conv_count, bus.req_ready} !== {1'b0, 16'(mCount), 4'b1000}) begin
      nMismatched++;
      $display("[TB] FAIL bp_release: got v=%b cnt=%0d rdy=%b expected 0/%0d/1000",
               bus.out_valid, bus.conv_count, bus.req_ready, mCount);
    end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    nCompared++;
    if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {1'b1, 2'd3, refConvert(d2)}) begin
      nMismatched++;
      $display("[TB] FAIL bp_second: got v=%b id=%0d SEF=%h expected 1/3/%h",
               bus.out_valid, bus.out_id, {bus.out_S, bus.out_E, bus.out_F}, refConvert(d2));
    end
    tick();
    mCount++;
  endtask

  task automatic test_extremes();
    int          rq[3];
    logic [11:0] dv[3];
    logic [7:0]  ex[3];
    rq = '{2, 3, 0};
    dv = '{12'h800, 12'h000, 12'h7FF};
    ex = '{8'b1_111_1111, 8'b0_000_0000, 8'b0_111_1111};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(rq[k], dv[k]);
      bus.req_valid = 4'(1 << rq[k]);
      tick();
      bus.req_valid = 4'b0000;
      tick();
      nCompared++;
      if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {1'b1, 2'(rq[k]), ex[k]}) begin
        nMismatched++;
        $display("[TB] FAIL extreme_%h: got v=%b id=%0d S=%b E=%0d F=%0d expected id=%0d SEF=%h",
                 dv[k], bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F, rq[k], ex[k]);
      end
      tick();
      mCount++;
      mPtr = (rq[k] + 1) % NREQ;
    end
  endtask

  task automatic test_random();
    logic [3:0]  v;
    logic [11:0] d;
    int          g, waitN;
    for (int it = 0; it < 60; it++) begin
      v = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'b0000;
      scrambleSlots();
      bus.req_valid = v;
      bus.out_ready = 1'b0;
      #1;
      g = refGrant(v, mPtr);
      nCompared++;
      if (bus.req_ready !== ((g < 0) ? 4'b0000 : 4'(1 << g))) begin
        nMismatched++;
        $display("[TB] FAIL rand_grant%0d: got %b valid=%b ptr=%0d expected grant %0d",
                 it, bus.req_ready, v, mPtr, g);
      end
      if (g < 0) begin
        tick();
        continue;
      end
      d = bus.req_data[g*12 +: 12];
      tick();
      bus.req_valid = 4'b0000;
      mPtr = (g + 1) % NREQ;
      tick();
      waitN = int'($urandom_range(0, 3));
      for (int w = 0; w <= waitN; w++) begin
        nCompared++;
        if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {1'b1, 2'(g), refConvert(d)}) begin
          nMismatched++;
          $display("[TB] FAIL rand_result%0d: got v=%b id=%0d SEF=%h expected id=%0d SEF=%h (data %h)",
                   it, bus.out_valid, bus.out_id, {bus.out_S, bus.out_E, bus.out_F}, g, refConvert(d), d);
        end
        if (w < waitN) tick();
      end
      bus.out_ready = 1'b1;
      tick();
      mCount++;
      nCompared++;
      if ({bus.out_valid, bus.conv_count} !== {1'b0, 16'(mCount)}) begin
        nMismatched++;
        $display("[TB] FAIL rand_accept%0d: got v=%b cnt=%0d expected 0/%0d", it, bus.out_valid, bus.conv_count, mCount);
      end
    end
  endtask

  task automatic test_reset_done();
    logic [11:0] d;
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    mPtr = 0;
    mCount = 0;
    bus.out_ready = 1'b0;
    applyStimulus(2, 12'h123);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1010;
    tick();
    nCompared++;
    if ({bus.out_valid, bus.req_ready} !== 5'b1_0000) begin
      nMismatched++;
      $display("[TB] FAIL rd_done: got v=%b rdy=%b expected 1/0000", bus.out_valid, bus.req_ready);
    end
    rst = 1'b1;
    #1;
    nCompared++;
    if (bus.req_ready !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL rd_ready_in_reset: got %b expected 0000", bus.req_ready);
    end
    tick();
    nCompared++;
    if ({bus.out_valid, bus.conv_count, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== 27'd0) begin
      nMismatched++;
      $display("[TB] FAIL rd_cleared: got v=%b cnt=%0d id=%0d SEF=%h expected all zero",
               bus.out_valid, bus.conv_count, bus.out_id, {bus.out_S, bus.out_E, bus.out_F});
    end
    rst = 1'b0;
    d = 12'($urandom);
    applyStimulus(1, d);
    #1;
    nCompared++;
    if (bus.req_ready !== 4'b0010) begin
      nMismatched++;
      $display("[TB] FAIL rd_regrant: got %b expected 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    tick();
    bus.out_ready = 1'b1;
    nCompared++;
    if ({bus.out_valid, bus.out_id, bus.out_S, bus.out_E, bus.out_F} !== {1'b1, 2'd1, refConvert(d)}) begin
      nMismatched++;
      $display("[TB] FAIL rd_result: got v=%b id=%0d SEF=%h expected 1/1/%h",
               bus.out_valid, bus.out_id, {bus.out_S, bus.out_E, bus.out_F}, refConvert(d));
    end
    tick();
    nCompared++;
    if (bus.conv_count !== 16'd1) begin
      nMismatched++;
      $display("[TB] FAIL rd_count: got %0d expected 1", bus.conv_count);
    end
  endtask

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    mPtr          = 0;
    mCount        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_extremes();
    test_random();
    test_reset_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
